// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between two
// queued writeback sources (A = ALU, B = load unit), with RAW pending flags.
module rf_wb_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          rg_wrt_en,
  output logic [AW-1:0] rg_wrt_addr,
  output logic [DW-1:0] rg_wrt_data,
  input  logic [AW-1:0] chk_addr1,
  input  logic [AW-1:0] chk_addr2,
  output logic          chk_pend1,
  output logic          chk_pend2,
  output logic          idle
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Index 0 = source A, index 1 = source B
  logic [1:0]    in_valid;
  logic [AW-1:0] in_addr [2];
  logic [DW-1:0] in_data [2];

  logic [AW-1:0] q_addr [2][DEPTH];
  logic [DW-1:0] q_data [2][DEPTH];
  logic [PW-1:0] wp [2];
  logic [PW-1:0] rp [2];
  logic [CW-1:0] cnt [2];

  logic [1:0]    ready;
  logic [1:0]    ne;
  logic [1:0]    push;
  logic [1:0]    grant;
  logic          gsel;
  logic          prio;
  logic [PW-1:0] off;
  logic          pend1;
  logic          pend2;

  assign in_valid   = {b_valid, a_valid};
  assign in_addr[0] = a_addr;
  assign in_addr[1] = b_addr;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;

  // Ready is a pure function of the current count; address-0 handshakes are dropped
  always_comb begin
    ready = '0;
    ne    = '0;
    push  = '0;
    for (int s = 0; s < 2; s++) begin
      ready[s] = (cnt[s] != FULL);
      ne[s]    = (cnt[s] != '0);
      push[s]  = in_valid[s] & ready[s] & (in_addr[s] != '0);
    end
  end

  // Round-robin grant; prio names the source favoured when both heads are valid
  always_comb begin
    grant = '0;
    if (ne[0] && ne[1]) begin
      grant[prio] = 1'b1;
    end else if (ne[0]) begin
      grant[0] = 1'b1;
    end else if (ne[1]) begin
      grant[1] = 1'b1;
    end
  end

  assign gsel = grant[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        wp[s]  <= '0;
        rp[s]  <= '0;
        cnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wp[s] <= wp[s] + PW'(1);
        if (grant[s]) rp[s] <= rp[s] + PW'(1);
        case ({push[s], grant[s]})
          2'b10:   cnt[s] <= cnt[s] + CW'(1);
          2'b01:   cnt[s] <= cnt[s] - CW'(1);
          default: cnt[s] <= cnt[s];
        endcase
      end
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and counts
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        q_addr[s][wp[s]] <= in_addr[s];
        q_data[s][wp[s]] <= in_data[s];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rg_wrt_en   <= 1'b0;
      rg_wrt_addr <= '0;
      rg_wrt_data <= '0;
      prio        <= 1'b0;
    end else begin
      rg_wrt_en <= |grant;
      if (|grant) begin
        rg_wrt_addr <= q_addr[gsel][rp[gsel]];
        rg_wrt_data <= q_data[gsel][rp[gsel]];
        prio        <= ~gsel;
      end
    end
  end

  // A write is pending while queued in either FIFO or presented on the port
  always_comb begin
    pend1 = rg_wrt_en && (rg_wrt_addr == chk_addr1);
    pend2 = rg_wrt_en && (rg_wrt_addr == chk_addr2);
    off   = '0;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        off = PW'(j) - rp[s];
        if (CW'(off) < cnt[s]) begin
          if (q_addr[s][j] == chk_addr1) pend1 = 1'b1;
          if (q_addr[s][j] == chk_addr2) pend2 = 1'b1;
        end
      end
    end
    if (chk_addr1 == '0) pend1 = 1'b0;
    if (chk_addr2 == '0) pend2 = 1'b0;
  end

  assign a_ready   = ready[0];
  assign b_ready   = ready[1];
  assign chk_pend1 = pend1;
  assign chk_pend2 = pend2;
  assign idle      = !ne[0] && !ne[1] && !rg_wrt_en;

  a_no_dual_addr: assert property (@(posedge clk) disable iff (!reset)
    !(push[0] && push[1] && (a_addr == b_addr)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table plus multi-cycle
// sequences, with a per-source scoreboard checking every port write.
module tb_rf_wb_arbiter;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          rg_wrt_en;
  logic [AW-1:0] rg_wrt_addr;
  logic [DW-1:0] rg_wrt_data;
  logic [AW-1:0] chk_addr1 = '0, chk_addr2 = '0;
  logic          chk_pend1, chk_pend2, idle;

  rf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr), .rg_wrt_data(rg_wrt_data),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_pend1(chk_pend1), .chk_pend2(chk_pend2), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic          src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] c2;
    logic          exp_wr;
    logic          exp_p2;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  wr_t exp_a[$];
  wr_t exp_b[$];
  logic [AW-1:0] obs_addr[$];
  int obs_cyc[$];
  logic a_rdy_h [64];
  logic b_rdy_h [64];
  wr_t mon_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: each port write must match the head of its source's queue
  always @(negedge clk) begin
    if (reset && rg_wrt_en) begin
      obs_addr.push_back(rg_wrt_addr);
      obs_cyc.push_back(cyc);
      if (exp_a.size() != 0 && exp_a[0].addr == rg_wrt_addr) begin
        mon_w = exp_a.pop_front();
        check("port_data_a", 64'(rg_wrt_data), 64'(mon_w.data));
      end else if (exp_b.size() != 0 && exp_b[0].addr == rg_wrt_addr) begin
        mon_w = exp_b.pop_front();
        check("port_data_b", 64'(rg_wrt_data), 64'(mon_w.data));
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL port_unexpected: got write addr %0d data %0h, want no write (cycle %0d)",
                 rg_wrt_addr, rg_wrt_data, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_a.delete();
    exp_b.delete();
    obs_addr.delete();
    obs_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7;
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h8;
    chk_addr1 = 5'd7; chk_addr2 = 5'd8;
    tick(); tick();
    check("rst_en",    64'(rg_wrt_en), 64'(0));
    check("rst_addr",  64'(rg_wrt_addr), 64'(0));
    check("rst_data",  64'(rg_wrt_data), 64'(0));
    check("rst_aready", 64'(a_ready), 64'(1));
    check("rst_bready", 64'(b_ready), 64'(1));
    check("rst_idle",  64'(idle), 64'(1));
    check("rst_pend",  64'({chk_pend1, chk_pend2}), 64'(0));
    a_valid = 1'b0; b_valid = 1'b0;
    chk_addr1 = '0; chk_addr2 = '0;
    clear_sb();
    #2 reset = 1'b1;
    tick(); tick();
    check("rst_hs_ignored_idle", 64'(idle), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(idle && exp_a.size() == 0 && exp_b.size() == 0) && k < budget) begin
      tick();
      k++;
    end
    check("drain_in_budget", 64'(k < budget), 64'(1));
  endtask

  // Streams na writes from A (starting at cycle a_delay) and nb writes from B
  task automatic stream(input int na, input int a_base, input int a_delay,
                        input int nb, input int b_base, output int a_acc_cyc);
    int ia, ib, k;
    logic va, vb, ra, rb;
    wr_t w;
    ia = 0; ib = 0; k = 0; a_acc_cyc = -1;
    while ((ia < na || ib < nb) && k < 60) begin
      va = (ia < na) && (k >= a_delay);
      vb = (ib < nb);
      a_valid = va; a_addr = AW'(a_base + ia); a_data = DW'((a_base + ia) * 17);
      b_valid = vb; b_addr = AW'(b_base + ib); b_data = DW'((b_base + ib) * 17);
      ra = a_ready; rb = b_ready;
      a_rdy_h[k] = ra; b_rdy_h[k] = rb;
      if (va && ra) begin w.addr = a_addr; w.data = a_data; exp_a.push_back(w); end
      if (vb && rb) begin w.addr = b_addr; w.data = b_data; exp_b.push_back(w); end
      tick();
      k++;
      if (va && ra) begin
        if (a_acc_cyc < 0) a_acc_cyc = cyc;
        ia++;
      end
      if (vb && rb) ib++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("stream_all_accepted", 64'(ia == na && ib == nb), 64'(1));
  endtask

  task automatic check_order(input string name, input logic [AW-1:0] ord [6]);
    check({name, "_len"}, 64'(obs_addr.size()), 64'(6));
    for (int i = 0; i < 6; i++)
      if (i < obs_addr.size()) check(name, 64'(obs_addr[i]), 64'(ord[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [6];
    wr_t w;
    logic [AW-1:0] ord [6];
    int ac, idx;

    vt[0] = '{1'b0, 5'd5,  32'hDEADBEEF, 5'd5,  1'b1, 1'b1};
    vt[1] = '{1'b1, 5'd9,  32'h00001234, 5'd8,  1'b1, 1'b0};
    vt[2] = '{1'b0, 5'd31, 32'hA5A5A5A5, 5'd31, 1'b1, 1'b1};
    vt[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  1'b0, 1'b0};
    vt[4] = '{1'b0, 5'd0,  32'h12345678, 5'd1,  1'b0, 1'b0};
    vt[5] = '{1'b1, 5'd17, 32'h00000000, 5'd16, 1'b1, 1'b0};

    do_reset();

    // Single writes: latency, pending window, address-0 drop, idle
    for (int i = 0; i < 6; i++) begin
      if (vt[i].src) begin b_valid = 1'b1; b_addr = vt[i].addr; b_data = vt[i].data; end
      else begin a_valid = 1'b1; a_addr = vt[i].addr; a_data = vt[i].data; end
      chk_addr1 = vt[i].addr;
      chk_addr2 = vt[i].c2;
      check("v_ready", 64'(vt[i].src ? b_ready : a_ready), 64'(1));
      if (vt[i].exp_wr) begin
        w.addr = vt[i].addr; w.data = vt[i].data;
        if (vt[i].src) exp_b.push_back(w); else exp_a.push_back(w);
      end
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      check("v_pend_queued", 64'(chk_pend1), 64'(vt[i].exp_wr));
      check("v_pend2_queued", 64'(chk_pend2), 64'(vt[i].exp_p2));
      check("v_en_edge1", 64'(rg_wrt_en), 64'(0));
      check("v_idle_edge1", 64'(idle), 64'(!vt[i].exp_wr));
      tick();
      check("v_en_edge2", 64'(rg_wrt_en), 64'(vt[i].exp_wr));
      check("v_pend_port", 64'(chk_pend1), 64'(vt[i].exp_wr));
      check("v_idle_edge2", 64'(idle), 64'(!vt[i].exp_wr));
      if (vt[i].exp_wr) begin
        check("v_port_addr", 64'(rg_wrt_addr), 64'(vt[i].addr));
        check("v_port_data", 64'(rg_wrt_data), 64'(vt[i].data));
      end
      tick();
      check("v_en_after", 64'(rg_wrt_en), 64'(0));
      check("v_pend_cleared", 64'({chk_pend1, chk_pend2}), 64'(0));
      check("v_idle_after", 64'(idle), 64'(1));
    end

    // Contention: both sources push three writes in the same cycles
    do_reset();
    stream(3, 1, 0, 3, 4, ac);
    wait_idle(40);
    check("rr_b_full_ready", 64'(b_rdy_h[2]), 64'(0));
    check("rr_a_full_ready", 64'(a_rdy_h[3]), 64'(0));
    ord = '{5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6};
    check_order("rr_order", ord);

    // No starvation: B streams continuously while A sends one write
    do_reset();
    stream(1, 3, 3, 6, 10, ac);
    wait_idle(40);
    idx = -1;
    for (int i = 0; i < obs_addr.size(); i++) if (obs_addr[i] == 5'd3) idx = i;
    check("starve_a_written", 64'(idx >= 0), 64'(1));
    if (idx >= 0) check("starve_a_latency", 64'(obs_cyc[idx] - ac <= 2), 64'(1));

    // Full FIFO with a pop in the same cycle does not refill until next cycle
    do_reset();
    stream(4, 20, 0, 2, 24, ac);
    wait_idle(40);
    check("full_no_refill", 64'(a_rdy_h[3]), 64'(0));
    check("full_refill_next", 64'(a_rdy_h[4]), 64'(1));
    ord = '{5'd20, 5'd24, 5'd21, 5'd25, 5'd22, 5'd23};
    check_order("full_order", ord);

    // Async reset mid-operation discards queued and in-flight writes
    do_reset();
    a_valid = 1'b1; a_addr = 5'd20; a_data = 32'h154;
    b_valid = 1'b1; b_addr = 5'd24; b_data = 32'h198;
    tick();
    a_valid = 1'b0; b_addr = 5'd25; b_data = 32'h1A9;
    tick();
    b_valid = 1'b0;
    check("midrst_pre_en", 64'(rg_wrt_en), 64'(1));
    check("midrst_pre_idle", 64'(idle), 64'(0));
    #2 reset = 1'b0;
    #1;
    check("midrst_en", 64'(rg_wrt_en), 64'(0));
    check("midrst_idle", 64'(idle), 64'(1));
    check("midrst_addr", 64'(rg_wrt_addr), 64'(0));
    clear_sb();
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("midrst_no_writes", 64'(obs_addr.size()), 64'(0));
    check("midrst_idle_after", 64'(idle), 64'(1));

    check("sb_empty", 64'(exp_a.size() + exp_b.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
